scalable_seq_detector_v2: RTL and testbench

Parametrised successor to the team's scalable sequence detector. Matches a run-time programmable sequence of up to SEQ_LEN multi-bit symbols against a qualified symbol stream. Uses correct fallback on mismatch: the longest suffix that is also a sequence prefix, KMP-equivalent. Adds selectable overlapping/non-overlapping detection, a match pulse, and a saturating match counter. Sits between a symbol source and control/status logic.

---
 rtl/seq_det_pkg.sv | 27 ++
 rtl/seq_det_prefix_match.sv | 46 ++++
 rtl/scalable_seq_detector_v2.sv | 139 +++++++++++++
 tb/tb_scalable_seq_detector_v2.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the scalable sequence detector.
// The ASCII status words are only used when SEQ_DET_MSG_EN is defined.
package seq_det_pkg;

    localparam logic [31:0] MSG_STAT = "stat";
    localparam logic [31:0] MSG_STOP = "stop";
    localparam logic [31:0] MSG_MID  = "mid.";
    localparam logic [31:0] MSG_1STH = "1sth";
    localparam logic [31:0] MSG_2NDH = "2ndh";
    localparam logic [31:0] MSG_EROR = "eror";

    // Width of curr_state: holds 0..SEQ_LEN-1.
    function automatic int state_w(input int seq_len);
        return (seq_len > 1) ? $clog2(seq_len) : 1;
    endfunction

    // Width of a length value: holds 0..SEQ_LEN.
    function automatic int len_w(input int seq_len);
        return $clog2(seq_len + 1);
    endfunction

    // A programmed length of 0 or above the maximum selects the full length.
    function automatic int len_clamp(input int len, input int max_len);
        return (len == 0 || len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_det_prefix_match.sv
// Combinational border search: for every candidate length j, checks whether
// the last j window symbols equal the first j sequence symbols. Only
// j <= curr_state+1 may win, so the history never needs a valid mask.
module seq_det_prefix_match
    import seq_det_pkg::*;
#(
    parameter int SEQ_LEN = 8,
    parameter int SYM_W   = 1
) (
    input  logic [SEQ_LEN-1:0][SYM_W-1:0]  window,
    input  logic [SEQ_LEN-1:0][SYM_W-1:0]  seq,
    input  logic [len_w(SEQ_LEN)-1:0]      len_q,
    input  logic [state_w(SEQ_LEN)-1:0]    curr_state,
    output logic                           full_hit,
    output logic [state_w(SEQ_LEN)-1:0]    best_border
);

    localparam int STATE_W = state_w(SEQ_LEN);

    logic [SEQ_LEN:1] cand;
    logic             ok;

    // Evaluate every candidate prefix length against the window tail.
    always_comb begin
        cand = '0;
        ok   = 1'b1;
        for (int j = 1; j <= SEQ_LEN; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (window[SEQ_LEN-j+i] != seq[i]) ok = 1'b0;
            end
            cand[j] = ok && (j <= int'(curr_state) + 1) && (j <= int'(len_q));
        end
    end

    // Pick the full-length hit and the longest proper border.
    always_comb begin
        full_hit    = 1'b0;
        best_border = '0;
        for (int j = 1; j <= SEQ_LEN; j++) begin
            if (j == int'(len_q)) full_hit = cand[j];
            if (cand[j] && (j < int'(len_q))) best_border = STATE_W'(j);
        end
    end

endmodule

// File: rtl/scalable_seq_detector_v2.sv
// Programmable multi-bit sequence detector with KMP-style fallback,
// overlapping/non-overlapping modes, match pulse and saturating counter.
// Define SEQ_DET_MSG_EN to add the 4-character ASCII status output msg.
module scalable_seq_detector_v2
    import seq_det_pkg::*;
#(
    parameter int SEQ_LEN = 8,
    parameter int SYM_W   = 1,
    parameter int CNT_W   = 16
) (
    input  logic                          clock0,
    input  logic                          reset,
    input  logic                          x_valid,
    input  logic [SYM_W-1:0]              x,
    input  logic                          cfg_load,
    input  logic [SEQ_LEN*SYM_W-1:0]      sequence_str,
    input  logic [$clog2(SEQ_LEN+1)-1:0]  seq_len,
    input  logic                          overlap_en,
    input  logic                          clear_count,
    output logic [$clog2(SEQ_LEN)-1:0]    curr_state,
    output logic                          match,
    output logic [CNT_W-1:0]              match_count,
    output logic                          start,
    output logic                          mid,
    output logic                          stop,
    output logic                          first_half,
    output logic                          second_half
`ifdef SEQ_DET_MSG_EN
    ,
    output logic [31:0]                   msg
`endif
);

    localparam int STATE_W = state_w(SEQ_LEN);
    localparam int LEN_W   = len_w(SEQ_LEN);

    logic [SEQ_LEN-1:0][SYM_W-1:0] seq_q, seq_d;
    logic [LEN_W-1:0]              len_q, len_d;
    logic                          ovl_q, ovl_d;
    logic [SEQ_LEN-2:0][SYM_W-1:0] hist_q, hist_d;
    logic [STATE_W-1:0]            state_q, state_d;
    logic                          match_q, match_d;
    logic [CNT_W-1:0]              count_q, count_d;

    logic [SEQ_LEN-1:0][SYM_W-1:0] window;
    logic                          full_hit;
    logic [STATE_W-1:0]            best_border;
    logic [LEN_W-1:0]              st_ext;
    logic [LEN_W-1:0]              half;

    // Newest symbol sits at the top index, oldest history at index 0.
    assign window = {x, hist_q};

    seq_det_prefix_match #(
        .SEQ_LEN (SEQ_LEN),
        .SYM_W   (SYM_W)
    ) u_match (
        .window      (window),
        .seq         (seq_q),
        .len_q       (len_q),
        .curr_state  (state_q),
        .full_hit    (full_hit),
        .best_border (best_border)
    );

    // Config load, history shift and next-state selection.
    always_comb begin
        seq_d   = seq_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        state_d = state_q;
        match_d = 1'b0;
        if (cfg_load) begin
            seq_d   = sequence_str;
            len_d   = LEN_W'(len_clamp(int'(seq_len), SEQ_LEN));
            ovl_d   = overlap_en;
            hist_d  = '0;
            state_d = '0;
        end else if (x_valid) begin
            for (int i = 0; i < SEQ_LEN - 1; i++) hist_d[i] = window[i+1];
            match_d = full_hit;
            state_d = (full_hit && !ovl_q) ? '0 : best_border;
        end
    end

    // Counter follows the registered pulse; clear beats increment.
    always_comb begin
        count_d = count_q;
        if (clear_count)                       count_d = '0;
        else if (match_q && (count_q != '1))   count_d = count_q + 1'b1;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock0) begin
        if (reset) begin
            seq_q   <= '0;
            len_q   <= LEN_W'(SEQ_LEN);
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            state_q <= '0;
            match_q <= 1'b0;
            count_q <= '0;
        end else begin
            seq_q   <= seq_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            state_q <= state_d;
            match_q <= match_d;
            count_q <= count_d;
        end
    end

    assign curr_state  = state_q;
    assign match       = match_q;
    assign match_count = count_q;

    assign st_ext      = LEN_W'(state_q);
    assign half        = len_q >> 1;
    assign start       = (state_q == '0);
    assign stop        = (st_ext == len_q - 1'b1);
    assign mid         = (st_ext == half);
    assign first_half  = (st_ext < half);
    assign second_half = (st_ext > half);

`ifdef SEQ_DET_MSG_EN
    // Status text, highest-priority flag first.
    always_comb begin
        msg = MSG_EROR;
        if (start)            msg = MSG_STAT;
        else if (stop)        msg = MSG_STOP;
        else if (mid)         msg = MSG_MID;
        else if (first_half)  msg = MSG_1STH;
        else if (second_half) msg = MSG_2NDH;
    end
`endif

endmodule

// File: tb/tb_scalable_seq_detector_v2.sv
// Directed-vector bench: each issued symbol pushes its expected state/match
// into a queue; a monitor pops one entry per accepted symbol.
module tb_scalable_seq_detector_v2;

    localparam int SEQ_LEN = 4;
    localparam int SYM_W   = 4;
    localparam int CNT_W   = 2;

    logic                     clock0 = 1'b0;
    logic                     reset, x_valid, cfg_load, overlap_en, clear_count;
    logic [SYM_W-1:0]         x;
    logic [SEQ_LEN*SYM_W-1:0] sequence_str;
    logic [2:0]               seq_len;
    logic [1:0]               curr_state;
    logic                     match;
    logic [CNT_W-1:0]         match_count;
    logic                     start, mid, stop, first_half, second_half;

    int n_tests = 0;
    int n_fail  = 0;
    int sym_id  = 0;

    typedef struct {
        int st;
        bit m;
        int id;
    } exp_t;
    exp_t exp_q[$];
    logic acc_seen = 1'b0;

    always #5 clock0 = ~clock0;

    scalable_seq_detector_v2 #(
        .SEQ_LEN (SEQ_LEN),
        .SYM_W   (SYM_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clock0       (clock0),
        .reset        (reset),
        .x_valid      (x_valid),
        .x            (x),
        .cfg_load     (cfg_load),
        .sequence_str (sequence_str),
        .seq_len      (seq_len),
        .overlap_en   (overlap_en),
        .clear_count  (clear_count),
        .curr_state   (curr_state),
        .match        (match),
        .match_count  (match_count),
        .start        (start),
        .mid          (mid),
        .stop         (stop),
        .first_half   (first_half),
        .second_half  (second_half)
    );

    task automatic chk(input string nm, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Remember whether the last edge accepted a symbol.
    always @(posedge clock0) acc_seen <= x_valid & ~cfg_load & ~reset;

    // Monitor: one scoreboard entry per accepted symbol; no pulse otherwise.
    always @(negedge clock0) begin : mon
        exp_t e;
        if (acc_seen) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("sym%0d_state", e.id), int'(curr_state), e.st);
                chk($sformatf("sym%0d_match", e.id), int'(match), int'(e.m));
            end
        end else begin
            chk("idle_no_match", int'(match), 0);
        end
    end

    task automatic sym(input logic [SYM_W-1:0] s, input int st, input bit m);
        x_valid = 1'b1;
        x       = s;
        sym_id++;
        exp_q.push_back('{st, m, sym_id});
        @(negedge clock0);
        x_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock0);
    endtask

    task automatic cfg(input logic [15:0] s, input logic [2:0] l, input bit o);
        cfg_load     = 1'b1;
        sequence_str = s;
        seq_len      = l;
        overlap_en   = o;
        @(negedge clock0);
        cfg_load = 1'b0;
    endtask

    task automatic clr();
        clear_count = 1'b1;
        @(negedge clock0);
        clear_count = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; x_valid = 1'b0; cfg_load = 1'b0; clear_count = 1'b0;
        x = '0; sequence_str = '0; seq_len = '0; overlap_en = 1'b1;
        repeat (2) @(negedge clock0);
        chk("rst_state", int'(curr_state), 0);
        chk("rst_match", int'(match), 0);
        chk("rst_count", int'(match_count), 0);
        chk("rst_start", int'(start), 1);
        chk("rst_first_half", int'(first_half), 1);
        chk("rst_mid", int'(mid), 0);
        chk("rst_stop", int'(stop), 0);
        chk("rst_second_half", int'(second_half), 0);
        reset = 1'b0;

        // 1,0,1,1 overlapping
        cfg(16'h1101, 3'd4, 1'b1);
        sym(4'h1, 1, 0); sym(4'h0, 2, 0); sym(4'h1, 3, 0);
        chk("t1_stop", int'(stop), 1);
        chk("t1_second_half", int'(second_half), 1);
        sym(4'h1, 1, 1); sym(4'h0, 2, 0);
        chk("t1_mid", int'(mid), 1);
        sym(4'h1, 3, 0); sym(4'h1, 1, 1);
        idle(1);
        chk("t1_count", int'(match_count), 2);

        // same stream, non-overlapping
        clr();
        chk("t2_cleared", int'(match_count), 0);
        cfg(16'h1101, 3'd4, 1'b0);
        sym(4'h1, 1, 0); sym(4'h0, 2, 0); sym(4'h1, 3, 0); sym(4'h1, 0, 1);
        sym(4'h0, 0, 0); sym(4'h1, 1, 0); sym(4'h1, 1, 0);
        idle(1);
        chk("t2_count", int'(match_count), 1);
        chk("t2_state", int'(curr_state), 1);

        // 1,1,0 fallback from state 2
        clr();
        cfg(16'h0011, 3'd3, 1'b1);
        sym(4'h1, 1, 0); sym(4'h1, 2, 0);
        chk("t3_stop_len3", int'(stop), 1);
        sym(4'h1, 2, 0); sym(4'h0, 0, 1);
        idle(1);
        chk("t3_count", int'(match_count), 1);

        // A,5 with idle gaps
        clr();
        cfg(16'h005A, 3'd2, 1'b1);
        sym(4'hA, 1, 0);
        idle(1); chk("t4_hold1", int'(curr_state), 1);
        idle(1); chk("t4_hold2", int'(curr_state), 1);
        sym(4'h5, 0, 1);
        idle(1);
        chk("t4_pulse_one_cycle", int'(match), 0);
        chk("t4_count", int'(match_count), 1);
        sym(4'hA, 1, 0); sym(4'h3, 0, 0);

        // A,A back-to-back pulses
        clr();
        cfg(16'h00AA, 3'd2, 1'b1);
        sym(4'hA, 1, 0); sym(4'hA, 1, 1); sym(4'hA, 1, 1);
        idle(1);
        chk("t4_b2b_count", int'(match_count), 2);

        // saturation and clear-vs-match
        clr();
        cfg(16'h005A, 3'd2, 1'b1);
        repeat (4) begin sym(4'hA, 1, 0); sym(4'h5, 0, 1); end
        idle(1); chk("t5_sat", int'(match_count), 3);
        idle(1); chk("t5_sat_hold", int'(match_count), 3);
        sym(4'hA, 1, 0); sym(4'h5, 0, 1);
        clear_count = 1'b1;
        @(negedge clock0);
        clear_count = 1'b0;
        chk("t5_clear_wins", int'(match_count), 0);
        idle(1); chk("t5_clear_stays", int'(match_count), 0);

        // reload at state 2 with seq_len=0; x_valid ignored during load
        clr();
        cfg(16'h0321, 3'd3, 1'b1);
        sym(4'h1, 1, 0); sym(4'h2, 2, 0);
        x_valid = 1'b1; x = 4'h3;
        cfg(16'h4321, 3'd0, 1'b1);
        x_valid = 1'b0;
        chk("t6_state_after_load", int'(curr_state), 0);
        chk("t6_start", int'(start), 1);
        sym(4'h1, 1, 0); chk("t6_stop_s1", int'(stop), 0);
        sym(4'h2, 2, 0); chk("t6_stop_s2", int'(stop), 0);
        chk("t6_mid_s2", int'(mid), 1);
        sym(4'h3, 3, 0); chk("t6_stop_s3", int'(stop), 1);
        sym(4'h4, 0, 1);
        reset = 1'b1;
        @(negedge clock0);
        reset = 1'b0;
        chk("t6_reset_drops_inc", int'(match_count), 0);

        // reset mid-sequence with default config (seq all zero, len 4)
        sym(4'h0, 1, 0); sym(4'h0, 2, 0);
        reset = 1'b1; x_valid = 1'b1; x = 4'h0;
        @(negedge clock0);
        reset = 1'b0; x_valid = 1'b0;
        chk("t7_state", int'(curr_state), 0);
        chk("t7_match", int'(match), 0);
        chk("t7_start", int'(start), 1);
        chk("t7_first_half", int'(first_half), 1);
        chk("t7_stop", int'(stop), 0);
        sym(4'h0, 1, 0); sym(4'h0, 2, 0); sym(4'h0, 3, 0); sym(4'h0, 3, 1);
        idle(2);
        chk("t7_count", int'(match_count), 1);

        chk("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
